// File: rtl/branch_checkpoint_ctrl.sv
// Branch checkpoint slot sequencer: in-order allocate/retire of snapshot slots, one-cycle restore on mispredict.
// Grant is combinational; restore_valid is asserted the cycle after a mispredict and recovery stalls decode for two cycles.
module branch_checkpoint_ctrl #(
  parameter int NUM_CKPT = 4,
  parameter int TAG_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_req,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  output logic             resolve_ready,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispredict,
  output logic             restore_valid,
  output logic [TAG_W-1:0] restore_tag,
  output logic             stall,
  output logic [TAG_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESTORE = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;
  localparam logic [TAG_W:0] FULL_CNT = NUM_CKPT[TAG_W:0];

  logic [1:0]          state;
  logic [TAG_W-1:0]    head, tail, mp_tag;
  logic [TAG_W:0]      cnt;
  logic [NUM_CKPT-1:0] valid, resolved, squash;
  logic                err_q;

  logic idle, tag_live, take_resolve, mp_accept, ok_accept, retire;

  assign idle         = (state == S_IDLE);
  assign tag_live     = valid[resolve_tag];
  assign take_resolve = idle && resolve_valid;
  assign mp_accept    = take_resolve && resolve_mispredict && tag_live;
  assign ok_accept    = take_resolve && !resolve_mispredict && tag_live;
  // Retire looks at registered resolved bits, so a resolve never retires in its own cycle.
  assign retire       = idle && valid[head] && resolved[head];

  assign full          = (cnt == FULL_CNT);
  assign empty         = (cnt == '0);
  assign count         = cnt;
  assign err           = err_q;
  assign alloc_tag     = tail;
  assign resolve_ready = idle;
  assign restore_valid = (state == S_RESTORE);
  assign restore_tag   = restore_valid ? mp_tag : '0;
  assign alloc_grant   = alloc_req && !full && idle && !(resolve_valid && resolve_mispredict);
  assign stall         = !idle || (alloc_req && !alloc_grant);

  // A slot is squashed when its age (distance from head) is at least that of the mispredicted slot.
  always_comb begin
    squash = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      squash[i] = ((TAG_W'(i) - head) >= (mp_tag - head));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      head     <= '0;
      tail     <= '0;
      mp_tag   <= '0;
      cnt      <= '0;
      valid    <= '0;
      resolved <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (alloc_grant) begin
            valid[tail]    <= 1'b1;
            resolved[tail] <= 1'b0;
            tail           <= tail + 1'b1;
          end
          if (ok_accept) resolved[resolve_tag] <= 1'b1;
          if (retire) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
          end
          if (alloc_grant && !retire)      cnt <= cnt + 1'b1;
          else if (!alloc_grant && retire) cnt <= cnt - 1'b1;
          if (take_resolve && !tag_live) err_q <= 1'b1;
          if (mp_accept) begin
            mp_tag <= resolve_tag;
            state  <= S_RESTORE;
          end
        end
        S_RESTORE: begin
          valid    <= valid & ~squash;
          resolved <= resolved & ~squash;
          tail     <= mp_tag;
          cnt      <= {1'b0, mp_tag - head};
          state    <= S_RECOVER;
        end
        S_RECOVER: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_ctrl.sv
// Bench for branch_checkpoint_ctrl: directed vector table, hand-written recovery/reset sequences, random run against a queue model.
module tb_branch_checkpoint_ctrl;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0, resolve_valid = 1'b0, resolve_mispredict = 1'b0;
  logic [1:0] resolve_tag = 2'd0;
  logic       alloc_grant, resolve_ready, restore_valid, stall, full, empty, err;
  logic [1:0] alloc_tag, restore_tag;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  branch_checkpoint_ctrl #(.NUM_CKPT(4), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_ready(resolve_ready),
    .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
    .restore_valid(restore_valid), .restore_tag(restore_tag), .stall(stall),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ar, input logic rv, input logic mp, input logic [1:0] rt);
    @(negedge clk);
    alloc_req = ar; resolve_valid = rv; resolve_mispredict = mp; resolve_tag = rt;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    alloc_req = 0; resolve_valid = 0; resolve_mispredict = 0; resolve_tag = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic ar, rv, mp; logic [1:0] rt;
    logic g; logic [1:0] at; logic st, rsv; logic [1:0] rtg; logic rdy; logic [2:0] cnt; logic er;
  } vec_t;

  function automatic vec_t v(input logic ar, input logic rv, input logic mp, input logic [1:0] rt,
                             input logic g, input logic [1:0] at, input logic st, input logic rsv,
                             input logic [1:0] rtg, input logic rdy, input logic [2:0] cnt, input logic er);
    vec_t r;
    r.ar = ar; r.rv = rv; r.mp = mp; r.rt = rt; r.g = g; r.at = at; r.st = st;
    r.rsv = rsv; r.rtg = rtg; r.rdy = rdy; r.cnt = cnt; r.er = er;
    return r;
  endfunction

  // Reference model: live checkpoints as an in-order queue of tags with resolved flags.
  int  q_tag[$];
  bit  q_res[$];
  int  m_tail, m_phase, m_mptag;
  bit  m_err;

  function automatic int find_tag(input int t);
    for (int k = 0; k < q_tag.size(); k++) if (q_tag[k] == t) return k;
    return -1;
  endfunction

  vec_t tbl[26];

  initial begin
    tbl[0]  = v(0,0,0,0, 0,0,0,0,0,1,0,0);
    tbl[1]  = v(1,0,0,0, 1,0,0,0,0,1,0,0);
    tbl[2]  = v(1,0,0,0, 1,1,0,0,0,1,1,0);
    tbl[3]  = v(1,0,0,0, 1,2,0,0,0,1,2,0);
    tbl[4]  = v(1,0,0,0, 1,3,0,0,0,1,3,0);
    tbl[5]  = v(1,0,0,0, 0,0,1,0,0,1,4,0);
    tbl[6]  = v(0,1,0,1, 0,0,0,0,0,1,4,0);
    tbl[7]  = v(0,1,0,0, 0,0,0,0,0,1,4,0);
    tbl[8]  = v(0,0,0,0, 0,0,0,0,0,1,4,0);
    tbl[9]  = v(0,0,0,0, 0,0,0,0,0,1,3,0);
    tbl[10] = v(1,1,1,3, 0,0,1,0,0,1,2,0);
    tbl[11] = v(1,0,0,0, 0,0,1,1,3,0,2,0);
    tbl[12] = v(1,0,0,0, 0,3,1,0,0,0,1,0);
    tbl[13] = v(1,0,0,0, 1,3,0,0,0,1,1,0);
    tbl[14] = v(1,0,0,0, 1,0,0,0,0,1,2,0);
    tbl[15] = v(0,1,0,2, 0,1,0,0,0,1,3,0);
    tbl[16] = v(0,0,0,0, 0,1,0,0,0,1,3,0);
    tbl[17] = v(0,0,0,0, 0,1,0,0,0,1,2,0);
    tbl[18] = v(0,1,1,0, 0,1,0,0,0,1,2,0);
    tbl[19] = v(0,0,0,0, 0,1,1,1,0,0,2,0);
    tbl[20] = v(0,0,0,0, 0,0,1,0,0,0,1,0);
    tbl[21] = v(0,1,0,3, 0,0,0,0,0,1,1,0);
    tbl[22] = v(0,0,0,0, 0,0,0,0,0,1,1,0);
    tbl[23] = v(0,1,0,2, 0,0,0,0,0,1,0,0);
    tbl[24] = v(0,0,0,0, 0,0,0,0,0,1,0,1);
    tbl[25] = v(0,1,0,1, 0,0,0,0,0,1,0,1);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].ar, tbl[i].rv, tbl[i].mp, tbl[i].rt);
      chk($sformatf("row%0d grant", i),    alloc_grant,   tbl[i].g);
      chk($sformatf("row%0d alloc_tag", i), alloc_tag,    tbl[i].at);
      chk($sformatf("row%0d stall", i),    stall,         tbl[i].st);
      chk($sformatf("row%0d restore_v", i), restore_valid, tbl[i].rsv);
      chk($sformatf("row%0d restore_t", i), restore_tag,   tbl[i].rtg);
      chk($sformatf("row%0d ready", i),    resolve_ready, tbl[i].rdy);
      chk($sformatf("row%0d count", i),    count,         tbl[i].cnt);
      chk($sformatf("row%0d full", i),     full,          tbl[i].cnt == 3'd4);
      chk($sformatf("row%0d empty", i),    empty,         tbl[i].cnt == 3'd0);
      chk($sformatf("row%0d err", i),      err,           tbl[i].er);
    end

    // Full buffer, mispredict the second-oldest branch, then reset in the middle of a restore.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      chk("seq grant", alloc_grant, 1);
      chk("seq tag", alloc_tag, 8'(i));
    end
    drive(0, 1, 1, 1);
    chk("seq full", full, 1);
    chk("seq mp ready", resolve_ready, 1);
    drive(0, 0, 0, 0);
    chk("seq N+1 restore_v", restore_valid, 1);
    chk("seq N+1 restore_t", restore_tag, 1);
    chk("seq N+1 stall", stall, 1);
    drive(0, 0, 0, 0);
    chk("seq N+2 restore_v", restore_valid, 0);
    chk("seq N+2 stall", stall, 1);
    drive(1, 0, 0, 0);
    chk("seq N+3 count", count, 1);
    chk("seq N+3 grant", alloc_grant, 1);
    chk("seq N+3 tag", alloc_tag, 1);
    drive(0, 1, 1, 1);
    drive(0, 0, 0, 0);
    chk("seq mid restore_v", restore_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst restore_v", restore_valid, 0);
    chk("arst empty", empty, 1);
    chk("arst count", count, 0);
    chk("arst stall", stall, 0);
    chk("arst ready", resolve_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the queue model.
    do_reset();
    q_tag.delete(); q_res.delete();
    m_tail = 0; m_phase = 0; m_mptag = 0; m_err = 0;
    for (int c = 0; c < 1500; c++) begin
      logic ar, rv, mp; logic [1:0] rt; bit eg, ret; int idx;
      ar = ($urandom_range(1) == 1);
      rv = ($urandom_range(9) < 4);
      mp = ($urandom_range(3) == 0);
      if (q_tag.size() > 0 && $urandom_range(19) != 0)
        rt = 2'(q_tag[$urandom_range(q_tag.size() - 1)]);
      else
        rt = 2'($urandom_range(3));
      idx = find_tag(int'(rt));
      if (mp && idx >= 0 && q_res[idx]) mp = 0;
      drive(ar, rv, mp, rt);

      eg = ar && q_tag.size() < N && m_phase == 0 && !(rv && mp);
      chk("rnd grant", alloc_grant, eg);
      chk("rnd alloc_tag", alloc_tag, 8'(m_tail));
      chk("rnd stall", stall, (m_phase != 0) || (ar && !eg));
      chk("rnd ready", resolve_ready, m_phase == 0);
      chk("rnd restore_v", restore_valid, m_phase == 1);
      chk("rnd restore_t", restore_tag, (m_phase == 1) ? 8'(m_mptag) : 8'd0);
      chk("rnd count", count, 8'(q_tag.size()));
      chk("rnd full", full, q_tag.size() == N);
      chk("rnd empty", empty, q_tag.size() == 0);
      chk("rnd err", err, m_err);

      if (m_phase == 0) begin
        ret = q_tag.size() > 0 && q_res[0];
        if (rv) begin
          if (idx < 0) m_err = 1;
          else if (mp) begin m_mptag = int'(rt); m_phase = 1; end
          else q_res[idx] = 1;
        end
        if (ret) begin void'(q_tag.pop_front()); void'(q_res.pop_front()); end
        if (eg) begin q_tag.push_back(m_tail); q_res.push_back(0); m_tail = (m_tail + 1) % N; end
      end else if (m_phase == 1) begin
        idx = find_tag(m_mptag);
        while (idx >= 0 && q_tag.size() > idx) begin void'(q_tag.pop_back()); void'(q_res.pop_back()); end
        m_tail = m_mptag;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
